// File: rtl/regfile_sb.sv
// Two-read / two-write register file with a per-register busy scoreboard.
// Decode reserves destinations; writeback writes and releases them.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        write_en,
    input  logic [ADDR_W-1:0] reg_write_addr_0,
    input  logic [ADDR_W-1:0] reg_write_addr_1,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [ADDR_W-1:0] read_addr_0,
    input  logic [ADDR_W-1:0] read_addr_1,
    output logic [DATA_W-1:0] read_data_0,
    output logic [DATA_W-1:0] read_data_1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              read_busy_0,
    output logic              read_busy_1,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              we0, we1, rsv_ok;
    logic              clr0, clr1, inc;
    logic [1:0]        dec;

    // Requests aimed at a hard-wired zero register are dropped here, so
    // neither storage nor the scoreboard ever sees them.
    always_comb begin
        we0    = write_en[0] && !(ZERO_REG != 0 && reg_write_addr_0 == '0);
        we1    = write_en[1] && !(ZERO_REG != 0 && reg_write_addr_1 == '0);
        rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
    end

    always_comb begin
        busy_next = busy;
        if (we0)
            busy_next[reg_write_addr_0] = 1'b0;
        if (we1)
            busy_next[reg_write_addr_1] = 1'b0;
        if (rsv_ok)
            busy_next[rsv_addr] = 1'b1;
        inc  = rsv_ok && !busy[rsv_addr];
        clr0 = we0 && busy[reg_write_addr_0] && !(rsv_ok && rsv_addr == reg_write_addr_0);
        // A second write to the same busy address releases nothing extra.
        clr1 = we1 && busy[reg_write_addr_1] && !(rsv_ok && rsv_addr == reg_write_addr_1)
               && !(we0 && reg_write_addr_0 == reg_write_addr_1);
        dec  = {1'b0, clr0} + {1'b0, clr1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (we0)
                regs[reg_write_addr_0] <= data_in_0;
            if (we1)
                regs[reg_write_addr_1] <= data_in_1;
            busy       <= busy_next;
            busy_count <= busy_count + CW'(inc) - CW'(dec);
        end
    end

    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rbusy [2];

    assign raddr[0]    = read_addr_0;
    assign raddr[1]    = read_addr_1;
    assign read_data_0 = rdata[0];
    assign read_data_1 = rdata[1];
    assign read_busy_0 = rbusy[0];
    assign read_busy_1 = rbusy[1];

    // Port 1 wins the bypass when both writes hit the read address, matching
    // what storage will hold after the edge.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            rbusy[p] = busy[raddr[p]];
            if (BYPASS != 0) begin
                if (we1 && reg_write_addr_1 == raddr[p])
                    rdata[p] = data_in_1;
                else if (we0 && reg_write_addr_0 == raddr[p])
                    rdata[p] = data_in_0;
                if (((we0 && reg_write_addr_0 == raddr[p]) || (we1 && reg_write_addr_1 == raddr[p]))
                    && !(rsv_ok && rsv_addr == raddr[p]))
                    rbusy[p] = 1'b0;
            end
            if (rst || (ZERO_REG != 0 && raddr[p] == '0)) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a plain instance, a bypass/zero-register
// instance sharing its inputs, and a 32x32 instance for the wide sweep.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  write_en;
    logic [2:0]  wa0, wa1, ra0, ra1, rsva;
    logic [15:0] wd0, wd1;
    logic        rsv_en;

    logic [15:0] a_rd0, a_rd1, b_rd0, b_rd1;
    logic        a_rb0, a_rb1, b_rb0, b_rb1;
    logic [3:0]  a_cnt, b_cnt;

    logic [1:0]  c_we;
    logic [4:0]  c_wa0, c_wa1, c_ra0, c_ra1, c_rsva;
    logic [31:0] c_wd0, c_wd1, c_rd0, c_rd1;
    logic        c_rsv, c_rb0, c_rb1;
    logic [5:0]  c_cnt;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dutA (
        .clk(clk), .rst(rst), .write_en(write_en),
        .reg_write_addr_0(wa0), .reg_write_addr_1(wa1),
        .data_in_0(wd0), .data_in_1(wd1),
        .read_addr_0(ra0), .read_addr_1(ra1),
        .read_data_0(a_rd0), .read_data_1(a_rd1),
        .rsv_en(rsv_en), .rsv_addr(rsva),
        .read_busy_0(a_rb0), .read_busy_1(a_rb1), .busy_count(a_cnt)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dutB (
        .clk(clk), .rst(rst), .write_en(write_en),
        .reg_write_addr_0(wa0), .reg_write_addr_1(wa1),
        .data_in_0(wd0), .data_in_1(wd1),
        .read_addr_0(ra0), .read_addr_1(ra1),
        .read_data_0(b_rd0), .read_data_1(b_rd1),
        .rsv_en(rsv_en), .rsv_addr(rsva),
        .read_busy_0(b_rb0), .read_busy_1(b_rb1), .busy_count(b_cnt)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(0)) dutC (
        .clk(clk), .rst(rst), .write_en(c_we),
        .reg_write_addr_0(c_wa0), .reg_write_addr_1(c_wa1),
        .data_in_0(c_wd0), .data_in_1(c_wd1),
        .read_addr_0(c_ra0), .read_addr_1(c_ra1),
        .read_data_0(c_rd0), .read_data_1(c_rd1),
        .rsv_en(c_rsv), .rsv_addr(c_rsva),
        .read_busy_0(c_rb0), .read_busy_1(c_rb1), .busy_count(c_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] we, input logic [2:0] a0, input logic [15:0] d0,
                                 input logic [2:0] a1, input logic [15:0] d1,
                                 input logic [2:0] r0, input logic [2:0] r1,
                                 input logic rsv, input logic [2:0] ra);
        write_en = we; wa0 = a0; wd0 = d0; wa1 = a1; wd1 = d1;
        ra0 = r0; ra1 = r1; rsv_en = rsv; rsva = ra;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pattern(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'h00010101;
    endfunction

    initial begin
        c_we = 2'b00; c_wa0 = '0; c_wa1 = '0; c_wd0 = '0; c_wd1 = '0;
        c_ra0 = '0; c_ra1 = '0; c_rsv = 1'b0; c_rsva = '0;

        // Reset: outputs forced low while rst is high, counts cleared at the edge.
        rst = 1'b1;
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0, 3'd0);
        checkOutput("rst_rd0_A", 32'(a_rd0), 32'h0);
        stepClock();
        checkOutput("rst_cnt_A", 32'(a_cnt), 32'd0);
        checkOutput("rst_cnt_C", 32'(c_cnt), 32'd0);
        rst = 1'b0;

        // Write 0xBEEF to r3, then reset must wipe it.
        applyStimulus(2'b01, 3'd3, 16'hBEEF, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0, 3'd0);
        checkOutput("bypass_beef_B", 32'(b_rd0), 32'hBEEF);
        checkOutput("nobypass_old_A", 32'(a_rd0), 32'h0);
        stepClock();
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0, 3'd0);
        checkOutput("write_beef_A", 32'(a_rd0), 32'hBEEF);
        rst = 1'b1;
        #1;
        checkOutput("inrst_rd0_A", 32'(a_rd0), 32'h0);
        checkOutput("inrst_rd1_A", 32'(a_rd1), 32'h0);
        checkOutput("inrst_rd1_B", 32'(b_rd1), 32'h0);
        stepClock();
        rst = 1'b0;
        #1;
        checkOutput("postrst_r3_A", 32'(a_rd0), 32'h0);
        checkOutput("postrst_cnt_A", 32'(a_cnt), 32'd0);

        // Collision: both ports to r5, port 1 wins.
        applyStimulus(2'b11, 3'd5, 16'h1111, 3'd5, 16'h2222, 3'd5, 3'd5, 1'b0, 3'd0);
        checkOutput("coll_bypass_B", 32'(b_rd0), 32'h2222);
        stepClock();
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b0, 3'd0);
        checkOutput("coll_r5_A", 32'(a_rd0), 32'h2222);
        checkOutput("coll_r5_B", 32'(b_rd1), 32'h2222);

        // Scoreboard: reserve r2, r4, r2.
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd4, 3'd2, 1'b1, 3'd2);
        stepClock();
        checkOutput("rsv1_cnt_A", 32'(a_cnt), 32'd1);
        checkOutput("rsv1_busy_A", 32'(a_rb1), 32'd1);
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd4, 3'd2, 1'b1, 3'd4);
        stepClock();
        checkOutput("rsv2_cnt_A", 32'(a_cnt), 32'd2);
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd4, 3'd2, 1'b1, 3'd2);
        stepClock();
        checkOutput("rsv3_cnt_A", 32'(a_cnt), 32'd2);
        checkOutput("rsv3_cnt_B", 32'(b_cnt), 32'd2);

        // Release r2 by writing it.
        applyStimulus(2'b01, 3'd2, 16'h0A0A, 3'd0, 16'h0, 3'd4, 3'd2, 1'b0, 3'd0);
        checkOutput("rel_samecyc_busy_B", 32'(b_rb1), 32'd0);
        checkOutput("rel_samecyc_busy_A", 32'(a_rb1), 32'd1);
        stepClock();
        checkOutput("rel_busy_A", 32'(a_rb1), 32'd0);
        checkOutput("rel_cnt_A", 32'(a_cnt), 32'd1);

        // Write and reserve r4 together: reservation wins, data still stored.
        applyStimulus(2'b01, 3'd4, 16'h4444, 3'd0, 16'h0, 3'd4, 3'd2, 1'b1, 3'd4);
        checkOutput("wr_rsv_samecyc_busy_B", 32'(b_rb0), 32'd1);
        stepClock();
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd4, 3'd2, 1'b0, 3'd0);
        checkOutput("wr_rsv_busy_A", 32'(a_rb0), 32'd1);
        checkOutput("wr_rsv_data_A", 32'(a_rd0), 32'h4444);
        checkOutput("wr_rsv_cnt_A", 32'(a_cnt), 32'd1);
        checkOutput("wr_rsv_cnt_B", 32'(b_cnt), 32'd1);

        // Release r4, then reserve r1 and r6 and release both in one edge.
        applyStimulus(2'b01, 3'd4, 16'h4445, 3'd0, 16'h0, 3'd1, 3'd6, 1'b0, 3'd0);
        stepClock();
        checkOutput("r4_rel_cnt_A", 32'(a_cnt), 32'd0);
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd1, 3'd6, 1'b1, 3'd1);
        stepClock();
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd1, 3'd6, 1'b1, 3'd6);
        stepClock();
        checkOutput("dual_pre_cnt_A", 32'(a_cnt), 32'd2);
        applyStimulus(2'b11, 3'd1, 16'h0101, 3'd6, 16'h0606, 3'd1, 3'd6, 1'b0, 3'd0);
        stepClock();
        checkOutput("dual_rel_cnt_A", 32'(a_cnt), 32'd0);
        checkOutput("dual_rel_cnt_B", 32'(b_cnt), 32'd0);
        checkOutput("dual_r6_A", 32'(a_rd1), 32'h0606);

        // Both ports hit busy r1: only one release.
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd1, 3'd6, 1'b1, 3'd1);
        stepClock();
        checkOutput("same_pre_cnt_A", 32'(a_cnt), 32'd1);
        applyStimulus(2'b11, 3'd1, 16'hAAAA, 3'd1, 16'hBBBB, 3'd1, 3'd6, 1'b0, 3'd0);
        stepClock();
        checkOutput("same_rel_cnt_A", 32'(a_cnt), 32'd0);
        checkOutput("same_rel_r1_A", 32'(a_rd0), 32'hBBBB);

        // Zero register: A stores into r0, B ignores it.
        applyStimulus(2'b01, 3'd0, 16'hFFFF, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 3'd0);
        checkOutput("zero_samecyc_rd_B", 32'(b_rd0), 32'h0);
        checkOutput("zero_samecyc_busy_B", 32'(b_rb0), 32'd0);
        stepClock();
        applyStimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
        checkOutput("zero_rd_A", 32'(a_rd0), 32'hFFFF);
        checkOutput("zero_busy_A", 32'(a_rb0), 32'd1);
        checkOutput("zero_cnt_A", 32'(a_cnt), 32'd1);
        checkOutput("zero_rd_B", 32'(b_rd0), 32'h0);
        checkOutput("zero_busy_B", 32'(b_rb0), 32'd0);
        checkOutput("zero_cnt_B", 32'(b_cnt), 32'd0);

        // Wide sweep on the 32x32 instance.
        for (int i = 0; i < 32; i++) begin
            c_we = 2'b01; c_wa0 = 5'(i); c_wd0 = pattern(i);
            stepClock();
        end
        c_we = 2'b00;
        for (int i = 0; i < 32; i++) begin
            c_ra0 = 5'(i); c_ra1 = 5'(31 - i);
            #1;
            checkOutput($sformatf("sweep_rd0_r%0d", i), c_rd0, pattern(i));
            checkOutput($sformatf("sweep_rd1_r%0d", 31 - i), c_rd1, pattern(31 - i));
        end
        for (int i = 0; i < 32; i++) begin
            c_rsv = 1'b1; c_rsva = 5'(i);
            stepClock();
        end
        c_rsv = 1'b0;
        c_ra0 = 5'd31;
        #1;
        checkOutput("sweep_peak_cnt", 32'(c_cnt), 32'd32);
        checkOutput("sweep_r31_busy", 32'(c_rb0), 32'd1);
        for (int i = 0; i < 16; i++) begin
            c_we = 2'b11; c_wa0 = 5'(2 * i); c_wa1 = 5'(2 * i + 1);
            c_wd0 = 32'h0; c_wd1 = 32'h0;
            stepClock();
            if (i == 0)
                checkOutput("sweep_first_rel_cnt", 32'(c_cnt), 32'd30);
        end
        c_we = 2'b00;
        #1;
        checkOutput("sweep_final_cnt", 32'(c_cnt), 32'd0);
        checkOutput("sweep_r31_idle", 32'(c_rb0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised two-read / two-write register file with an integrated scoreboard, for the RISC datapath. It generalises the register file in data width and depth, and defines write-port collision priority. It adds optional write-to-read bypass, an optional hard-wired zero register, and per-register busy tracking so the control unit can detect read-after-write hazards on in-flight results. It sits between decode (reads, reservations) and writeback (writes, releases).

## Interface

Parameters:
- `DATA_W`, 16, register width in bits.
- `ADDR_W`, 3, address width; depth = 2**ADDR_W registers.
- `BYPASS`, 0, 1 = same-cycle write data forwarded to read ports.
- `ZERO_REG`, 0, 1 = register 0 reads as zero and is never written, reserved or busy.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `write_en` in 2: bit 0 enables write port 0; bit 1 enables write port 1.
- `reg_write_addr_0`, `reg_write_addr_1` in ADDR_W: write addresses.
- `data_in_0`, `data_in_1` in DATA_W: write data.
- `read_addr_0`, `read_addr_1` in ADDR_W: read addresses.
- `read_data_0`, `read_data_1` out DATA_W: read data, combinational.
- `rsv_en` in 1: reserve a destination register, setting its busy bit.
- `rsv_addr` in ADDR_W: register to reserve.
- `read_busy_0`, `read_busy_1` out 1: busy status of `read_addr_0` / `read_addr_1`, combinational.
- `busy_count` out ADDR_W+1: number of registers currently busy, registered.

## Operation

Storage:
- Array of 2**ADDR_W × DATA_W registers, plus a busy vector of 2**ADDR_W bits.
- Both are cleared only by reset.

Writes:
- Write port 0 commits when `write_en[0]=1`; write port 1 commits when `write_en[1]=1`.
- Both ports may commit in the same cycle.
- If both ports target the same address, port 1's data is stored.
- A committed write clears the busy bit of its address (release on writeback).

Reservation:
- `rsv_en=1` sets `busy[rsv_addr]`.
- If a write to the same address commits in the same cycle, the reservation wins and the bit stays set; the write data is still stored.
- Reserving an already-busy register leaves it set and does not change the count.

Reads:
- `read_data_x` = `regs[read_addr_x]`.
- When `BYPASS=1` and a write port commits this cycle to `read_addr_x`, the write data is returned instead; port 1 has priority if both ports match.
- `read_busy_x` = `busy[read_addr_x]`.
- When `BYPASS=1` and a same-cycle write targets `read_addr_x` with no same-cycle reservation of that address, `read_busy_x` = 0.

Zero register (`ZERO_REG=1`):
- Address 0 always reads 0 and reports `read_busy` = 0.
- Writes and reservations to address 0 are ignored and do not affect `busy_count`.

`busy_count`:
- Next value = current count + (reservation newly setting a clear bit ? 1 : 0) − (number of distinct addresses whose busy bit is cleared this cycle).
- It must always equal the population count of the busy vector.

Reset behaviour:
- While `rst=1`, `read_data_0/1` = 0 and `read_busy_0/1` = 0, regardless of state.
- At the `rst` clock edge, all registers become 0, all busy bits 0, and `busy_count` = 0.
- Reset overrides any write or reservation presented in the same cycle.
- Reset mid-operation discards all outstanding reservations.

## Timing

- Write latency: data is visible on the read ports the cycle after the commit edge when `BYPASS=0`, or combinationally in the same cycle when `BYPASS=1`.
- Reservation latency: `read_busy` asserts the cycle after the `rsv_en` edge.
- Release latency: `read_busy` deasserts the cycle after the write edge (`BYPASS=0`), or in the same cycle (`BYPASS=1`).
- `busy_count` updates on the same edge as the busy vector; it has no combinational path from inputs.
- There are no stalls or handshakes: every request is accepted every cycle.

## Test plan

- **Reset clears state:** write 0xBEEF to r3, then pulse `rst` for one cycle → `read_addr_0=3` gives 0x0000, `busy_count`=0; during `rst` both read ports show 0.
- **Collision priority:** `write_en`=11, both addresses 5, `data_in_0`=0x1111, `data_in_1`=0x2222 → next cycle r5 reads 0x2222. With `BYPASS=1`, `read_data_0` shows 0x2222 in the same cycle.
- **Scoreboard:** reserve r2, r4, r2 on three consecutive cycles → `busy_count` goes 1, 2, 2. Then write r2 → `read_busy` for r2 drops and `busy_count`=1. Then write r4 and reserve r4 in the same cycle → r4 stays busy, r4 reads the new data, `busy_count`=1.
- **Dual release:** r1 and r6 busy, dual write to r1 and r6 → `busy_count` 2→0 in one edge. Dual write with both ports to r1 while busy → count decrements by 1 only.
- **Zero register (`ZERO_REG=1`):** write 0xFFFF to r0 and reserve r0 → r0 reads 0, `read_busy`=0, `busy_count` unchanged. With `ZERO_REG=0`, r0 stores 0xFFFF.
- **Width/depth sweep:** `DATA_W`=32, `ADDR_W`=5 → write a distinct pattern to each of 32 registers, read all back through both ports, and reserve/release all 32 → `busy_count` peaks at 32 and returns to 0.
